// File: rtl/uart_tx_fifo_if.sv
// Byte stream between the TX FIFO and the UART transmitter.
//   m_axis_tdata  : head-of-queue byte (FIFO -> transmitter)
//   m_axis_tvalid : head byte is valid (FIFO -> transmitter)
//   m_axis_tready : transmitter accepts the head byte (transmitter -> FIFO)
// master: the FIFO side that drives the stream. slave: the transmitter side.
interface uart_tx_fifo_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tready;

  modport master (
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// First-word fall-through byte FIFO feeding the UART transmitter.
// Absorbs single-cycle write strobes from the application and presents them one
// byte at a time over a valid/ready stream. Everything runs in the serial clock domain.
//   clk        : serial clock, rising edge
//   nrst       : synchronous active-low reset
//   wr_en      : push strobe, one byte per high cycle
//   wr_data    : byte to push
//   flush      : synchronous clear of all queued data (overflow untouched)
//   clear_ovf  : clears the sticky overflow flag
//   full       : count == DEPTH
//   count      : number of stored entries, 0..DEPTH
//   overflow   : sticky, a push was dropped because the FIFO was full
//   m_axis     : head-of-queue stream to the transmitter (master side)
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  flush,
  input  logic                  clear_ovf,
  output logic                  full,
  output logic [AW:0]           count,
  output logic                  overflow,
  uart_tx_fifo_if.master        m_axis
);

  localparam logic [AW:0]   DepthCnt = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PtrOne   = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_ptr_inc;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             tvalid_q, tvalid_d;
  logic [WIDTH-1:0] tdata_q, tdata_d;
  logic             ovf_q, ovf_d;
  logic             pop, push, drop;

  always_comb begin
    pop        = tvalid_q & m_axis.m_axis_tready;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    push       = wr_en & ~flush & (~full_q | pop);
    drop       = wr_en & ~flush & full_q & ~pop;
    rd_ptr_inc = rd_ptr_q + PtrOne;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    full_d   = full_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;

    // A drop outranks a clear in the same cycle.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      full_d   = 1'b0;
      tvalid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_inc;
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
      full_d   = (count_d == DepthCnt);
      tvalid_d = (count_d != '0);

      // Registered head: load the entry that becomes the head after this edge.
      // With two or more stored, the successor is already in memory and cannot be
      // the slot being written (that would need count == DEPTH + 1).
      if (pop) begin
        if (count_q > (AW+1)'(1)) begin
          tdata_d = mem_q[rd_ptr_inc];
        end else if (push) begin
          tdata_d = wr_data;
        end
      end else if ((count_q == '0) && push) begin
        tdata_d = wr_data;
      end
    end
  end

  // Storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (nrst && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      ovf_q    <= ovf_d;
    end
  end

  assign full                 = full_q;
  assign count                = count_q;
  assign overflow             = ovf_q;
  assign m_axis.m_axis_tdata  = tdata_q;
  assign m_axis.m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: the driver updates a queue-based model and
// pushes every accepted byte into exp_q; a monitor pops and compares on each
// handshake seen on the stream.
module tb_uart_tx_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic             clk = 1'b0;
  logic             nrst;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             flush;
  logic             clear_ovf;
  logic             full;
  logic [AW:0]      count;
  logic             overflow;

  uart_tx_fifo_if #(.WIDTH(WIDTH)) axis_if ();

  uart_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .flush     (flush),
    .clear_ovf (clear_ovf),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .m_axis    (axis_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: contents of the FIFO, sticky flag, last presented head byte.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic       m_ovf  = 1'b0;
  logic [7:0] m_last = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic n, input logic we, input logic [7:0] wd,
                       input logic fl, input logic co, input logic rdy);
    logic pop;
    logic drop;
    pop = (mq.size() > 0) && rdy;
    if (!n) begin
      mq.delete();
      exp_q.delete();
      m_ovf  = 1'b0;
      m_last = 8'h00;
    end else begin
      drop  = we && !fl && (mq.size() == DEPTH) && !pop;
      m_ovf = drop ? 1'b1 : (co ? 1'b0 : m_ovf);
      if (fl) begin
        mq.delete();
        exp_q.delete();
      end else begin
        if (pop) void'(mq.pop_front());
        if (we && !drop) begin
          mq.push_back(wd);
          exp_q.push_back(wd);
        end
      end
      if (mq.size() > 0) m_last = mq[0];
    end
  endtask

  task automatic step(input logic n, input logic we, input logic [7:0] wd,
                      input logic fl, input logic co, input logic rdy);
    nrst                  = n;
    wr_en                 = we;
    wr_data               = wd;
    flush                 = fl;
    clear_ovf             = co;
    axis_if.m_axis_tready = rdy;
    @(posedge clk);
    model(n, we, wd, fl, co, rdy);
    #1;
    chk("count", 32'(count), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("tvalid", 32'(axis_if.m_axis_tvalid), 32'(mq.size() != 0));
    chk("tdata", 32'(axis_if.m_axis_tdata), 32'(m_last));
  endtask

  task automatic fill(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 8'(base + i), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && mq.size() > 0; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: a handshake seen mid-cycle completes at the next rising edge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (nrst === 1'b1 && axis_if.m_axis_tvalid === 1'b1 && axis_if.m_axis_tready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL stream_underrun: got %0h expected no data", axis_if.m_axis_tdata);
      end else begin
        e = exp_q.pop_front();
        chk("stream", 32'(axis_if.m_axis_tdata), 32'(e));
      end
    end
  end

  initial begin
    int sent;
    logic we;
    logic rdy;

    // Reset held 3 cycles with a push pending, then one idle cycle after release.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Fall-through latency and stall hold.
    step(1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Fill, overflow on a dropped push, drain in order.
    fill(8'h00, 16);
    step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    drain();

    // Flush with a coincident push: data lost, sticky overflow kept.
    fill(8'h60, 5);
    step(1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Drop and clear in the same cycle: set wins. Then clear alone.
    fill(8'h80, 16);
    step(1'b1, 1'b1, 8'hBB, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    drain();

    // Push at full with a simultaneous pop is accepted.
    fill(8'h20, 16);
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    drain();

    // Wrap-around stream, tready toggling, at most 3 in flight.
    sent = 0;
    for (int c = 0; c < 400 && (sent < 40 || mq.size() > 0); c++) begin
      we = (sent < 40) && (mq.size() < 3);
      step(1'b1, we, 8'(8'h10 + sent), 1'b0, 1'b0, c[0]);
      if (we) sent++;
    end

    // Random traffic: slow consumer first to reach full, then balanced.
    for (int c = 0; c < 600; c++) begin
      rdy = (c < 300) ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
      step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 47) == 0),
           ($urandom_range(0, 15) == 0), rdy);
    end

    drain();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
